// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle between the edge-event arbiter and its consumer.
// The arbiter drives valid/channel/polarity; the consumer drives ready.
interface edge_event_arbiter_if #(
    parameter int CW = 2
);
    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic          evt_rise;
    logic          evt_ready;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_rise,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_rise,
        output evt_ready
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection with a one-deep pending slot per channel,
// round-robin granted onto a single registered valid/ready event port.
module edge_event_arbiter #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N-1:0]          level,
    input  logic [2*N-1:0]        mode,
    input  logic                  clr_ovf,
    output logic [N-1:0]          ovf,
    edge_event_arbiter_if.master  evt
);

    logic [N-1:0]  prev_q;
    logic [N-1:0]  pend_q, pend_d;
    logic [N-1:0]  pol_q, pol_d;
    logic [N-1:0]  ovf_q, ovf_d;
    logic          valid_q;
    logic [CW-1:0] ch_q;
    logic          rise_q;
    logic [CW-1:0] last_q;

    logic [N-1:0]  edge_rise, edge_fall, edge_hit, leaving;
    logic          out_free, grant_found, load;
    logic [CW-1:0] grant_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign edge_rise[gi] = level[gi] & ~prev_q[gi];
            assign edge_fall[gi] = ~level[gi] & prev_q[gi];
            assign edge_hit[gi]  = (edge_rise[gi] & mode[2*gi]) |
                                   (edge_fall[gi] & mode[2*gi+1]);
            assign leaving[gi]   = load && (grant_idx == CW'(gi));
        end
    endgenerate

    assign out_free = ~valid_q | evt.evt_ready;
    assign load     = out_free & grant_found;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last_q) + k) % N;
            if (!grant_found && pend_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = CW'(idx);
            end
        end
    end

    // An edge arriving while its slot drains refills the slot instead of overrunning.
    always_comb begin
        pend_d = pend_q;
        pol_d  = pol_q;
        ovf_d  = ovf_q & ~{N{clr_ovf}};
        for (int i = 0; i < N; i++) begin
            if (edge_hit[i]) begin
                if (!pend_q[i] || leaving[i]) begin
                    pend_d[i] = 1'b1;
                    pol_d[i]  = edge_rise[i];
                end else begin
                    ovf_d[i] = 1'b1;
                end
            end else if (leaving[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_q <= level;
        if (!reset_n) begin
            pend_q  <= '0;
            pol_q   <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            rise_q  <= 1'b0;
            last_q  <= CW'(N - 1);
        end else begin
            pend_q <= pend_d;
            pol_q  <= pol_d;
            ovf_q  <= ovf_d;
            if (out_free) begin
                valid_q <= grant_found;
                if (grant_found) begin
                    ch_q   <= grant_idx;
                    rise_q <= pol_q[grant_idx];
                    last_q <= grant_idx;
                end
            end
        end
    end

    assign evt.evt_valid = valid_q;
    assign evt.evt_ch    = ch_q;
    assign evt.evt_rise  = rise_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed vector table plus a reset-corner sequence for edge_event_arbiter.
module tb_edge_event_arbiter;

    logic       clk;
    logic       reset_n;
    logic [3:0] level;
    logic [7:0] mode;
    logic       clr_ovf;
    logic [3:0] ovf;

    int checks = 0;
    int errors = 0;

    edge_event_arbiter_if #(.CW(2)) evt_if ();

    edge_event_arbiter #(.N(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (level),
        .mode    (mode),
        .clr_ovf (clr_ovf),
        .ovf     (ovf),
        .evt     (evt_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] lvl;
        logic [7:0] md;
        logic       rdy;
        logic       clr;
        logic       e_valid;
        logic [1:0] e_ch;
        logic       e_rise;
        logic [3:0] e_ovf;
    } vec_t;

    vec_t tbl [40];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic ev, input logic [1:0] ech,
                             input logic er, input logic [3:0] eo);
        checks++;
        if (evt_if.evt_valid !== ev) begin
            errors++;
            $display("FAIL %s evt_valid got %b want %b", name, evt_if.evt_valid, ev);
        end
        checks++;
        if (evt_if.evt_ch !== ech) begin
            errors++;
            $display("FAIL %s evt_ch got %0d want %0d", name, evt_if.evt_ch, ech);
        end
        checks++;
        if (evt_if.evt_rise !== er) begin
            errors++;
            $display("FAIL %s evt_rise got %b want %b", name, evt_if.evt_rise, er);
        end
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf got %b want %b", name, ovf, eo);
        end
        $display("%s: valid=%b ch=%0d rise=%b ovf=%b", name, evt_if.evt_valid,
                 evt_if.evt_ch, evt_if.evt_rise, ovf);
    endtask

    initial begin
        //           rst  level    mode  rdy  clr   valid ch rise ovf
        tbl[0]  = '{1'b1, 4'b0000, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 4'b0100, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0100, 8'h55, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0100, 8'h55, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0100, 8'h55, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0101, 8'h57, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0101, 8'h57, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 4'b0101, 8'h57, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[8]  = '{1'b1, 4'b0100, 8'h57, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};
        tbl[9]  = '{1'b1, 4'b0100, 8'h57, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000};
        tbl[10] = '{1'b1, 4'b0100, 8'h57, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[11] = '{1'b0, 4'b0100, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[12] = '{1'b1, 4'b0100, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[13] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[14] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[15] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[16] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[17] = '{1'b1, 4'b0100, 8'h55, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[18] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[19] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[20] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[21] = '{1'b1, 4'b1111, 8'h55, 1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0000};
        tbl[22] = '{1'b1, 4'b0000, 8'h55, 1'b1, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[23] = '{1'b1, 4'b0010, 8'h5D, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 4'b0000};
        tbl[24] = '{1'b1, 4'b0000, 8'h5D, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[25] = '{1'b1, 4'b0010, 8'h5D, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[26] = '{1'b1, 4'b0010, 8'h5D, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[27] = '{1'b1, 4'b0010, 8'h5D, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0000};
        tbl[28] = '{1'b1, 4'b0010, 8'h5D, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4'b0000};
        tbl[29] = '{1'b1, 4'b0010, 8'h5D, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[30] = '{1'b1, 4'b0110, 8'h75, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[31] = '{1'b1, 4'b0010, 8'h75, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
        tbl[32] = '{1'b1, 4'b0010, 8'h75, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000};
        tbl[33] = '{1'b1, 4'b0010, 8'h75, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[34] = '{1'b1, 4'b0110, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[35] = '{1'b1, 4'b0010, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[36] = '{1'b1, 4'b0000, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[37] = '{1'b1, 4'b0001, 8'h55, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[38] = '{1'b1, 4'b0001, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000};
        tbl[39] = '{1'b1, 4'b0001, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000};

        reset_n = 1'b0;
        level   = 4'b0000;
        mode    = 8'h55;
        clr_ovf = 1'b0;
        evt_if.evt_ready = 1'b1;
        step();
        step();
        check_out("reset", 1'b0, 2'd0, 1'b0, 4'b0000);

        for (int i = 0; i < 40; i++) begin
            reset_n          = tbl[i].rst_n;
            level            = tbl[i].lvl;
            mode             = tbl[i].md;
            evt_if.evt_ready = tbl[i].rdy;
            clr_ovf          = tbl[i].clr;
            step();
            check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_ch,
                      tbl[i].e_rise, tbl[i].e_ovf);
        end

        // Reset while an event is presented and another is pending.
        reset_n = 1'b1; clr_ovf = 1'b0; mode = 8'h55; evt_if.evt_ready = 1'b1;
        level = 4'b1001;
        step();
        check_out("rst_seq_pend", 1'b0, 2'd0, 1'b1, 4'b0000);
        step();
        check_out("rst_seq_present", 1'b1, 2'd3, 1'b1, 4'b0000);
        evt_if.evt_ready = 1'b0;
        level = 4'b1011;
        step();
        check_out("rst_seq_hold", 1'b1, 2'd3, 1'b1, 4'b0000);
        reset_n = 1'b0;
        step();
        check_out("rst_seq_reset", 1'b0, 2'd0, 1'b0, 4'b0000);
        reset_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        step();
        check_out("rst_seq_idle1", 1'b0, 2'd0, 1'b0, 4'b0000);
        step();
        check_out("rst_seq_idle2", 1'b0, 2'd0, 1'b0, 4'b0000);
        level = 4'b1111;
        step();
        check_out("post_rst_detect", 1'b0, 2'd0, 1'b0, 4'b0000);
        step();
        check_out("post_rst_event", 1'b1, 2'd2, 1'b1, 4'b0000);
        step();
        check_out("post_rst_drain", 1'b0, 2'd2, 1'b1, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event controller that shares one event output between N level inputs. It detects configurable edges on each channel, queues one pending event per channel, and grants the channels round-robin onto a single valid/ready event port. It sits between the synchronized level sources of the FSM application blocks and the downstream event consumer. It replaces ad-hoc per-signal edge detectors that each need their own handshake.

## Interface
- N, 4, number of level channels (2..16)
- CW, $clog2(N), channel-index width (derived, not overridden)

- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset; one clock, synchronous, active-low
- level  in  N  per-channel level inputs, already synchronized to clk
- mode  in  2N  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- evt_ready  in  1  consumer accepts the event when high with evt_valid
- clr_ovf  in  1  clears all overrun flags (one-cycle pulse)
- evt_valid  out  1  event present on evt_ch/evt_rise
- evt_ch  out  CW  channel index of the presented event
- evt_rise  out  1  1 = rising edge, 0 = falling edge
- ovf  out  N  sticky per-channel overrun flags

## Operation
- Edge detection: register prev[i] <= level[i] every cycle.
  - rise[i] = level[i] & ~prev[i]; fall[i] = ~level[i] & prev[i].
  - Qualified edge q[i] = (rise & mode[0]) | (fall & mode[1]).
- During reset, prev loads level, so a channel held high through reset gives no spurious edge.
- Pending store: one entry per channel, pend[i] plus pol[i] (1 = rise).
  - q[i] with pend[i]=0 sets pend[i] and pol[i].
  - q[i] with pend[i]=1 not leaving this cycle: the event is dropped and ovf[i] is set. The stored polarity is kept (drop-newest).
  - q[i] in the same cycle that entry i moves to the output: the new edge becomes pending, with no overrun.
- Output register (evt_valid, evt_ch, evt_rise) is "free" when evt_valid=0 or evt_valid&evt_ready.
  - When free and any pend set, the arbiter loads the winning channel next cycle and clears its pend bit.
  - When free and nothing is pending, evt_valid drops to 0.
- Arbitration: round-robin. Search starts at last_grant+1 and wraps N-1 to 0. last_grant updates only on load.
- Handshake: evt_valid/evt_ch/evt_rise stay stable while evt_valid=1 and evt_ready=0. The consumer may hold ready high permanently.
- Mode change affects detection from the next sampled edge onward. Entries already pending are still delivered, including for mode 00.
- ovf[i] stays set until clr_ovf=1. If clr_ovf and a new overrun occur in the same cycle, the overrun wins (ovf stays 1).
- Reset (reset_n=0 at a clock edge) gives:
  - pend=0, pol=0, ovf=0, evt_valid=0, evt_ch=0, evt_rise=0.
  - last_grant=N-1, so channel 0 has first priority.
  - Reset mid-event discards all queued and presented events.

## Timing
- A level transition is sampled at edge k, and pend is set after edge k.
- With the output free and no contention, evt_valid=1 after edge k+1. Detection-to-valid latency is 2 cycles.
- Throughput is one event per cycle with evt_ready held high. Back-to-back loads are required, with no bubble between pending channels.
- Worst-case wait for a pending channel is N-1 grants.
- All outputs are registered. There is no combinational path from evt_ready or level to any output.
- The first event is possible 2 cycles after reset_n returns high.

## Test plan
- Reset, N=4, all modes 01. Channel 2 rises at edge 3 → evt_valid=1, evt_ch=2, evt_rise=1 after edge 4. It drops one cycle after acceptance. ovf=0.
- Mode 11 on channel 0, evt_ready=1. Level pulses high 3 cycles → two events: rise then fall, 3 cycles apart.
- Channels 0,1,3 all rise on the same edge, ready=1 → evt_ch 0,1,3 on consecutive cycles. Repeat the pattern: the order continues 0,1,3 (rotation from last_grant=3).
- Hold evt_ready=0 while channel 1 toggles twice with mode 11 → the first event (rise) is presented and stable. The second edge is dropped and ovf[1]=1. clr_ovf pulse → ovf[1]=0.
- Edge on channel 2 in the same cycle its pending entry is accepted → a second event for channel 2 follows, ovf[2]=0.
- Level high through reset, then reset_n=1 → no event. Assert reset while evt_valid=1 → evt_valid=0 and pending cleared next cycle. Mode 00 channel toggling → no event.
